cache_fill_fsm: RTL and testbench

Miss-service controller that sits between the data cache and the multicycle main memory and performs block fills. When the cache flags a miss, this block streams the 8 words of the missing 16-byte block out of memory. It writes each returned word into the cache data array, then commits the new tag/valid/LRU entry with a single tag-array write. The cache consumes `write_data_array` and `write_tag_array`; this block is their producer.

---
 rtl/cache_fill_fsm.sv | 120 ++++++++++++
 tb/tb_cache_fill_fsm.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_fsm.sv
// Block-fill controller between the data cache and multicycle main memory.
// Streams BLOCK_WORDS words of a missing block into the data array, then commits the tag.
module cache_fill_fsm #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int BLOCK_WORDS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_detected,
    input  logic [ADDR_WIDTH-1:0] miss_address,
    input  logic                  memory_data_valid,
    input  logic [DATA_WIDTH-1:0] memory_data,
    output logic                  fsm_busy,
    output logic                  memory_read,
    output logic [ADDR_WIDTH-1:0] memory_address,
    output logic                  write_data_array,
    output logic                  write_tag_array,
    output logic [ADDR_WIDTH-1:0] cache_address,
    output logic [DATA_WIDTH-1:0] cache_data
);

    localparam int CNT_W = $clog2(BLOCK_WORDS);
    localparam int OFF_W = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   base;
    logic [CNT_W-1:0]        issue_cnt;
    logic [CNT_W-1:0]        recv_cnt;
    logic                    issue_done;
    logic [ADDR_WIDTH-1:0]   miss_base;
    logic                    unused_offset_bits;

    assign miss_base          = {miss_address[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
    assign unused_offset_bits = ^miss_address[OFF_W-1:0];

    // Offsets are OR-ed into a block-aligned base, so they can never carry into the tag.
    function automatic logic [ADDR_WIDTH-1:0] word_off(input logic [CNT_W-1:0] cnt);
        return ADDR_WIDTH'({cnt, 1'b0});
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            base           <= '0;
            issue_cnt      <= '0;
            recv_cnt       <= '0;
            issue_done     <= 1'b0;
            fsm_busy       <= 1'b0;
            memory_read    <= 1'b0;
            memory_address <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_detected) begin
                        state          <= FILL;
                        base           <= miss_base;
                        issue_cnt      <= '0;
                        recv_cnt       <= '0;
                        issue_done     <= 1'b0;
                        fsm_busy       <= 1'b1;
                        memory_read    <= 1'b1;
                        memory_address <= miss_base;
                    end
                end
                FILL: begin
                    if (!issue_done) begin
                        issue_cnt <= issue_cnt + CNT_ONE;
                        if (issue_cnt == CNT_LAST) begin
                            issue_done     <= 1'b1;
                            memory_read    <= 1'b0;
                            memory_address <= '0;
                        end else begin
                            memory_address <= base | word_off(issue_cnt + CNT_ONE);
                        end
                    end
                    if (memory_data_valid) begin
                        recv_cnt <= recv_cnt + CNT_ONE;
                        if (recv_cnt == CNT_LAST) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state          <= IDLE;
                    fsm_busy       <= 1'b0;
                    memory_read    <= 1'b0;
                    memory_address <= '0;
                end
                default: begin
                    state    <= IDLE;
                    fsm_busy <= 1'b0;
                end
            endcase
        end
    end

    // Returned words are written in the same cycle they arrive.
    assign write_data_array = (state == FILL) && memory_data_valid;
    assign write_tag_array  = (state == DONE);
    assign cache_data       = memory_data;

    always_comb begin
        cache_address = '0;
        if (write_data_array) begin
            cache_address = base | word_off(recv_cnt);
        end else if (state == DONE) begin
            cache_address = base;
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed scoreboard bench for cache_fill_fsm: stimulus pushes expected
// requests/writes/tag commits; a negedge monitor pops and compares them.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = '0;
    logic        memory_data_valid = 1'b0;
    logic [15:0] memory_data = '0;
    logic        fsm_busy;
    logic        memory_read;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic        write_tag_array;
    logic [15:0] cache_address;
    logic [15:0] cache_data;

    cache_fill_fsm #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (16),
        .BLOCK_WORDS(8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .miss_detected    (miss_detected),
        .miss_address     (miss_address),
        .memory_data_valid(memory_data_valid),
        .memory_data      (memory_data),
        .fsm_busy         (fsm_busy),
        .memory_read      (memory_read),
        .memory_address   (memory_address),
        .write_data_array (write_data_array),
        .write_tag_array  (write_tag_array),
        .cache_address    (cache_address),
        .cache_data       (cache_data)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   errors = 0;
    int   checks = 0;
    logic exp_busy = 1'b0;

    typedef struct {
        int          cyc;
        logic [15:0] addr;
        logic [15:0] data;
    } ent_t;

    ent_t q_req[$];
    ent_t q_wr[$];
    ent_t q_tag[$];

    int g0[8];
    int g_irr[8];

    task automatic check(input string name, input bit ok, input string got, input string want);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %s, expected %s", name, got, want);
        end
    endtask

    function automatic logic [15:0] word(input logic [15:0] b, input int i);
        return (b ^ 16'hA5C3) + 16'(i * 16'h0111);
    endfunction

    // Monitor: samples mid-cycle, away from the rising edge.
    always begin
        ent_t e;
        @(negedge clk);
        #2;
        if (rst) begin
            check("busy", fsm_busy === exp_busy,
                  $sformatf("%b @%0d", fsm_busy, cyc), $sformatf("%b", exp_busy));
            if (memory_read === 1'b1) begin
                if (q_req.size() == 0) begin
                    check("req_unexpected", 1'b0, $sformatf("read %h @%0d", memory_address, cyc), "no read");
                end else begin
                    e = q_req.pop_front();
                    check("req", memory_address === e.addr && cyc == e.cyc,
                          $sformatf("%h @%0d", memory_address, cyc), $sformatf("%h @%0d", e.addr, e.cyc));
                end
            end
            if (write_data_array === 1'b1) begin
                if (q_wr.size() == 0) begin
                    check("wr_unexpected", 1'b0, $sformatf("write %h @%0d", cache_address, cyc), "no write");
                end else begin
                    e = q_wr.pop_front();
                    check("wr", cache_address === e.addr && cache_data === e.data && cyc == e.cyc,
                          $sformatf("%h=%h @%0d", cache_address, cache_data, cyc),
                          $sformatf("%h=%h @%0d", e.addr, e.data, e.cyc));
                end
            end
            if (write_tag_array === 1'b1) begin
                if (q_tag.size() == 0) begin
                    check("tag_unexpected", 1'b0, $sformatf("tag %h @%0d", cache_address, cyc), "no tag");
                end else begin
                    e = q_tag.pop_front();
                    check("tag", cache_address === e.addr && cyc == e.cyc,
                          $sformatf("%h @%0d", cache_address, cyc), $sformatf("%h @%0d", e.addr, e.cyc));
                end
            end
        end
    end

    // One fill: miss in cycle 0, word i returns at 1+lat+i plus accumulated gaps.
    // p1/p2: cycles where a stray miss (address 0x7770) is pulsed.
    task automatic fill(input logic [15:0] addr, input int lat, input int gap[8],
                        input int p1, input int p2, input bit done_valid);
        int          rel[8];
        int          t0, tt, idx;
        logic [15:0] b;
        ent_t        e;
        b = {addr[15:4], 4'h0};
        @(negedge clk);
        miss_detected     = 1'b1;
        miss_address      = addr;
        memory_data_valid = 1'b0;
        exp_busy          = 1'b0;
        t0 = cyc;
        for (int i = 0; i < 8; i++) begin
            rel[i] = ((i == 0) ? 1 + lat : rel[i-1] + 1) + gap[i];
            e.cyc = t0 + 1 + i; e.addr = b + 16'(2 * i); e.data = '0;
            q_req.push_back(e);
            e.cyc = t0 + rel[i]; e.data = word(b, i);
            q_wr.push_back(e);
        end
        tt = rel[7] + 1;
        e.cyc = t0 + tt; e.addr = b; e.data = '0;
        q_tag.push_back(e);
        idx = 0;
        for (int k = 1; k <= tt; k++) begin
            @(negedge clk);
            exp_busy      = 1'b1;
            miss_detected = (k == p1) || (k == p2);
            miss_address  = miss_detected ? 16'h7770 : addr;
            if (idx < 8 && k == rel[idx]) begin
                memory_data_valid = 1'b1;
                memory_data       = word(b, idx);
                idx++;
            end else begin
                memory_data_valid = (k == tt) && done_valid;
                memory_data       = 16'hDEAD;
            end
        end
    endtask

    task automatic idle(input int n, input bit v);
        repeat (n) begin
            @(negedge clk);
            miss_detected     = 1'b0;
            memory_data_valid = v;
            memory_data       = 16'hBEEF;
            exp_busy          = 1'b0;
        end
    endtask

    // Reset asserted mid-cycle 6 of a 4-cycle-latency fill.
    task automatic reset_mid(input logic [15:0] addr);
        logic [15:0] b;
        ent_t        e;
        b = {addr[15:4], 4'h0};
        @(negedge clk);
        miss_detected = 1'b1;
        miss_address  = addr;
        exp_busy      = 1'b0;
        for (int i = 0; i < 6; i++) begin
            e.cyc = cyc + 1 + i; e.addr = b + 16'(2 * i); e.data = '0;
            q_req.push_back(e);
        end
        for (int i = 0; i < 2; i++) begin
            e.cyc = cyc + 5 + i; e.addr = b + 16'(2 * i); e.data = word(b, i);
            q_wr.push_back(e);
        end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            miss_detected     = 1'b0;
            exp_busy          = 1'b1;
            memory_data_valid = (k >= 5);
            memory_data       = (k >= 5) ? word(b, k - 5) : 16'hDEAD;
        end
        #4 rst = 1'b0;
        #2;
        check("rst_busy",  fsm_busy === 1'b0,         $sformatf("%b", fsm_busy), "0");
        check("rst_read",  memory_read === 1'b0,      $sformatf("%b", memory_read), "0");
        check("rst_maddr", memory_address === 16'h0, $sformatf("%h", memory_address), "0000");
        check("rst_wda",   write_data_array === 1'b0, $sformatf("%b", write_data_array), "0");
        check("rst_wta",   write_tag_array === 1'b0,  $sformatf("%b", write_tag_array), "0");
        check("rst_caddr", cache_address === 16'h0,  $sformatf("%h", cache_address), "0000");
        @(negedge clk);
        exp_busy = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        memory_data_valid = 1'b1;
        idle(3, 1'b1);
        idle(1, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            g0[i]    = 0;
            g_irr[i] = (i == 4 || i == 5) ? 2 : 0;
        end
        memory_data = 16'h1357;
        #3;
        check("reset_busy",  fsm_busy === 1'b0,         $sformatf("%b", fsm_busy), "0");
        check("reset_read",  memory_read === 1'b0,      $sformatf("%b", memory_read), "0");
        check("reset_maddr", memory_address === 16'h0, $sformatf("%h", memory_address), "0000");
        check("reset_wda",   write_data_array === 1'b0, $sformatf("%b", write_data_array), "0");
        check("reset_wta",   write_tag_array === 1'b0,  $sformatf("%b", write_tag_array), "0");
        check("reset_caddr", cache_address === 16'h0,  $sformatf("%h", cache_address), "0000");
        check("reset_cdata", cache_data === 16'h1357,  $sformatf("%h", cache_data), "1357");
        @(negedge clk);
        rst = 1'b1;
        idle(2, 1'b0);

        fill(16'h1234, 4, g0, 0, 0, 1'b0);
        idle(2, 1'b0);
        fill(16'hFFFE, 3, g0, 0, 0, 1'b0);
        idle(2, 1'b0);
        fill(16'h4A5C, 2, g_irr, 0, 0, 1'b0);
        idle(2, 1'b0);
        fill(16'h2468, 4, g0, 3, 13, 1'b0);
        fill(16'h0BCD, 5, g0, 0, 0, 1'b0);
        idle(2, 1'b0);
        fill(16'h3000, 1, g0, 0, 0, 1'b1);
        idle(2, 1'b0);
        reset_mid(16'h5678);
        idle(3, 1'b1);
        fill(16'h9ABC, 6, g0, 0, 0, 1'b0);
        idle(3, 1'b0);

        check("left_req", q_req.size() == 0, $sformatf("%0d pending", q_req.size()), "0 pending");
        check("left_wr",  q_wr.size() == 0,  $sformatf("%0d pending", q_wr.size()),  "0 pending");
        check("left_tag", q_tag.size() == 0, $sformatf("%0d pending", q_tag.size()), "0 pending");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
